// File: rtl/addr_req_sequencer.sv
// addr_req_sequencer: walks an address range and runs one four-phase
// REQ/ACK handshake per address, with per-phase timeout and bounded retry.
module addr_req_sequencer #(
   parameter int ADDR_W      = 2,
   parameter int TIMEOUT_CYC = 255,
   parameter int MAX_RETRY   = 3,
   parameter int CNT_W       = 8
) (
   input  logic              CLK_IN,
   input  logic              RST_IN,
   input  logic              START_IN,
   input  logic [ADDR_W-1:0] ADDR_FIRST_IN,
   input  logic [ADDR_W-1:0] ADDR_LAST_IN,
   input  logic              ACK_IN,
   output logic              REQ_OUT,
   output logic [ADDR_W-1:0] MY_ADDR_OUT,
   output logic              BUSY_OUT,
   output logic              DONE_OUT,
   output logic              ERR_OUT,
   output logic [ADDR_W-1:0] ERR_ADDR_OUT,
   output logic [CNT_W-1:0]  XFER_CNT_OUT
);

   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
   localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ_HI,
      S_REQ_LO,
      S_NEXT,
      S_ERR,
      S_FIN
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] last_q, last_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic [RTY_W-1:0]  rty_q, rty_d;
   logic              rflag_q, rflag_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] eaddr_q, eaddr_d;

   logic              timeout;
   logic              in_req;

   assign timeout = (tmr_q == TMR_LAST);
   assign in_req  = (state_q == S_REQ_HI) || (state_q == S_REQ_LO);

   // Next-state, handshake sequencing and bookkeeping updates
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      last_d  = last_q;
      rty_d   = rty_q;
      rflag_d = rflag_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      eaddr_d = eaddr_q;
      unique case (state_q)
         S_IDLE: begin
            if (START_IN) begin
               addr_d  = ADDR_FIRST_IN;
               last_d  = ADDR_LAST_IN;
               err_d   = 1'b0;
               eaddr_d = '0;
               cnt_d   = '0;
               rty_d   = '0;
               rflag_d = 1'b0;
               state_d = S_REQ_HI;
            end
         end
         S_REQ_HI: begin
            // An ACK on the timeout cycle still counts as an ACK.
            if (ACK_IN) begin
               state_d = S_REQ_LO;
            end else if (timeout) begin
               if (rty_q < RTY_MAX) begin
                  rty_d   = rty_q + RTY_W'(1);
                  rflag_d = 1'b1;
                  state_d = S_REQ_LO;
               end else begin
                  err_d   = 1'b1;
                  eaddr_d = addr_q;
                  state_d = S_ERR;
               end
            end
         end
         S_REQ_LO: begin
            if (!ACK_IN) begin
               if (rflag_q) begin
                  rflag_d = 1'b0;
                  state_d = S_REQ_HI;
               end else begin
                  if (cnt_q != CNT_MAX) begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
                  if (addr_q == last_q) begin
                     state_d = S_FIN;
                  end else begin
                     // Advance now so the new address leads REQ by a cycle.
                     addr_d  = addr_q + ADDR_W'(1);
                     state_d = S_NEXT;
                  end
               end
            end else if (timeout) begin
               err_d   = 1'b1;
               eaddr_d = addr_q;
               state_d = S_ERR;
            end
         end
         S_NEXT: begin
            rty_d   = '0;
            state_d = S_REQ_HI;
         end
         S_ERR: begin
            state_d = S_FIN;
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Timer restarts on every state change and only runs in REQ phases
   always_comb begin
      tmr_d = '0;
      if (in_req && (state_d == state_q)) begin
         tmr_d = tmr_q + TMR_W'(1);
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge CLK_IN) begin
      if (RST_IN) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         last_q  <= '0;
         tmr_q   <= '0;
         rty_q   <= '0;
         rflag_q <= 1'b0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         eaddr_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         last_q  <= last_d;
         tmr_q   <= tmr_d;
         rty_q   <= rty_d;
         rflag_q <= rflag_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         eaddr_q <= eaddr_d;
      end
   end

   assign REQ_OUT      = (state_q == S_REQ_HI);
   assign BUSY_OUT     = (state_q != S_IDLE);
   assign DONE_OUT     = (state_q == S_FIN);
   assign MY_ADDR_OUT  = addr_q;
   assign ERR_OUT      = err_q;
   assign ERR_ADDR_OUT = eaddr_q;
   assign XFER_CNT_OUT = cnt_q;

endmodule
